// File: rtl/simd_alu_array.sv
// rtl/simd_alu_array.sv - LANES-wide SIMD ALU array: private register file per lane, shared instruction stream
//
// Purpose:
//   Every lane owns 2**ADDR_W registers of DATA_W bits. One instruction
//   (op, rs1, rs2, rd, sat_en, wb_en) is applied to all lanes at once.
//   Two-stage pipeline:
//     S1 : operands read combinationally from the register files and
//          registered together with the decoded instruction fields.
//     S2 : ALU result registered into result; optional writeback to rd
//          in every lane on the same edge.
//   A read-after-write interlock stalls issue while S1 holds a pending
//   writeback to either source register. There is no forwarding.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   in_valid/ready  issue handshake for op/sat_en/wb_en/rs1/rs2/rd
//   op              000 ADD, 001 SUB, 010 BITREV, 011 MUL,
//                   100 AND, 101 OR,  110 XOR,    111 PASS (rs1)
//   sat_en          signed saturation for ADD/SUB/MUL
//   wb_en           write the result back to rd in all lanes
//   ld_en/addr/mask/data  external per-lane register load, independent of
//                   the handshake; lane i is ld_data[i*DATA_W +: DATA_W]
//   out_valid/ready result handshake
//   result          per-lane results, same packing as ld_data

module simd_alu_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic                    sat_en,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       rs1,
  input  logic [ADDR_W-1:0]       rs2,
  input  logic [ADDR_W-1:0]       rd,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [LANES-1:0]        ld_mask,
  input  logic [LANES*DATA_W-1:0] ld_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] result
);

  localparam int NREG = 1 << ADDR_W;
  localparam int VW   = LANES * DATA_W;

  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_BITREV = 3'b010,
    OP_MUL    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110,
    OP_PASS   = 3'b111
  } op_e;

  // S1 pipeline register
  logic              s1_valid;
  op_e               s1_op;
  logic              s1_sat;
  logic              s1_wb;
  logic [ADDR_W-1:0] s1_rd;
  logic [VW-1:0]     s1_a;
  logic [VW-1:0]     s1_b;

  // Combinational register reads and ALU outputs for all lanes
  logic [VW-1:0]     rd_a;
  logic [VW-1:0]     rd_b;
  logic [VW-1:0]     alu_y;

  logic              s2_adv;
  logic              hazard;
  logic              accept;
  logic              s1_fire;
  logic              wb_fire;

  // S2 can take a new entry when it is empty or its result is being consumed.
  assign s2_adv  = !out_valid || out_ready;

  // The interlock looks at rs1 and rs2 regardless of whether the op uses rs2,
  // which keeps the check independent of opcode decode.
  assign hazard  = s1_valid && s1_wb && ((s1_rd == rs1) || (s1_rd == rs2));

  assign in_ready = rst && (!s1_valid || (s2_adv && !hazard));
  assign accept   = in_valid && in_ready;
  assign s1_fire  = s1_valid && s2_adv;
  assign wb_fire  = s1_fire && s1_wb;

  // ------------------------------------------------------------------
  // S1 register: captures operands for all lanes plus the shared fields.
  // An accept while S1 is occupied implies s2_adv, so the old entry is
  // moving to S2 on the same edge.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_sat   <= 1'b0;
      s1_wb    <= 1'b0;
      s1_rd    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(op);
      s1_sat   <= sat_en;
      s1_wb    <= wb_en;
      s1_rd    <= rd;
      s1_a     <= rd_a;
      s1_b     <= rd_b;
    end else if (s1_fire) begin
      s1_valid <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // S2 register: result and out_valid hold while the consumer stalls.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= alu_y;
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-lane register file and ALU
  // ------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [NREG-1:0][DATA_W-1:0] mem;
    logic [DATA_W-1:0]           a;
    logic [DATA_W-1:0]           b;
    logic [DATA_W-1:0]           y;
    logic [DATA_W-1:0]           rev;
    logic [DATA_W:0]             sum;
    logic [DATA_W:0]             dif;
    logic [2*DATA_W-1:0]         prod;
    logic                        mul_ovf;

    assign rd_a[g*DATA_W +: DATA_W] = mem[rs1];
    assign rd_b[g*DATA_W +: DATA_W] = mem[rs2];

    // The load is the later assignment, so it overrides a writeback to the
    // same address in this lane; unmasked lanes keep the writeback.
    always_ff @(posedge clk) begin
      if (!rst) begin
        mem <= '0;
      end else begin
        if (wb_fire) begin
          mem[s1_rd] <= alu_y[g*DATA_W +: DATA_W];
        end
        if (ld_en && ld_mask[g]) begin
          mem[ld_addr] <= ld_data[g*DATA_W +: DATA_W];
        end
      end
    end

    assign a = s1_a[g*DATA_W +: DATA_W];
    assign b = s1_b[g*DATA_W +: DATA_W];

    // One extra sign bit makes signed overflow visible as a mismatch of the
    // top two bits; the low DATA_W bits are the modulo result either way.
    assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    assign dif = {a[DATA_W-1], a} - {b[DATA_W-1], b};

    // Multiplying the sign-extended operands gives the exact 2*DATA_W-bit
    // signed product; its low half equals the unsigned modulo product.
    assign prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

    // The product fits in DATA_W signed bits only if its top DATA_W+1 bits
    // are all copies of the sign.
    assign mul_ovf = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));

    always_comb begin
      rev = '0;
      for (int i = 0; i < DATA_W; i++) begin
        rev[i] = a[DATA_W-1-i];
      end
    end

    always_comb begin
      y = a;
      case (s1_op)
        OP_ADD: begin
          if (s1_sat && (sum[DATA_W] != sum[DATA_W-1])) begin
            y = sum[DATA_W] ? SMIN : SMAX;
          end else begin
            y = sum[DATA_W-1:0];
          end
        end
        OP_SUB: begin
          if (s1_sat && (dif[DATA_W] != dif[DATA_W-1])) begin
            y = dif[DATA_W] ? SMIN : SMAX;
          end else begin
            y = dif[DATA_W-1:0];
          end
        end
        OP_BITREV: y = rev;
        OP_MUL: begin
          if (s1_sat && mul_ovf) begin
            y = prod[2*DATA_W-1] ? SMIN : SMAX;
          end else begin
            y = prod[DATA_W-1:0];
          end
        end
        OP_AND:  y = a & b;
        OP_OR:   y = a | b;
        OP_XOR:  y = a ^ b;
        OP_PASS: y = a;
        default: y = a;
      endcase
    end

    assign alu_y[g*DATA_W +: DATA_W] = y;
  end

endmodule

// File: tb/tb_simd_alu_array.sv
// tb/tb_simd_alu_array.sv - scoreboard bench for simd_alu_array with an instruction-level reference model

module tb_simd_alu_array;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int VW     = LANES * DATA_W;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, BREV = 3'b010, MUL = 3'b011;
  localparam logic [2:0] AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, PASS = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic              sat_en;
  logic              wb_en;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [LANES-1:0]  ld_mask;
  logic [VW-1:0]     ld_data;
  logic              out_valid;
  logic              out_ready;
  logic [VW-1:0]     result;

  always #5 clk = ~clk;

  simd_alu_array #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sat_en(sat_en), .wb_en(wb_en),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  int checks = 0;
  int errors = 0;

  // Architectural state as a program-order machine: every accepted
  // instruction sees all earlier writebacks and loads.
  logic [DATA_W-1:0] mrf [LANES][NREG];
  logic [VW-1:0]     exp_q [$];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic longint clampv(input longint v);
    longint lo, hi;
    lo = -(longint'(1) <<< (DATA_W-1));
    hi = (longint'(1) <<< (DATA_W-1)) - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sval(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? longint'(x) - (longint'(1) <<< DATA_W) : longint'(x);
  endfunction

  function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] o, input logic s,
                                                input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    longint r;
    logic [63:0] rr;
    logic [DATA_W-1:0] rv;
    r = 0;
    rv = '0;
    case (o)
      ADD:  r = s ? clampv(sval(a) + sval(b)) : longint'(a) + longint'(b);
      SUB:  r = s ? clampv(sval(a) - sval(b)) : longint'(a) - longint'(b);
      MUL:  r = s ? clampv(sval(a) * sval(b)) : longint'(a) * longint'(b);
      BREV: begin
        for (int i = 0; i < DATA_W; i++) rv[i] = a[DATA_W-1-i];
        r = longint'(rv);
      end
      AND_: r = longint'(a & b);
      OR_:  r = longint'(a | b);
      XOR_: r = longint'(a ^ b);
      default: r = longint'(a);
    endcase
    rr = r;
    return rr[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0100;
      4: return 16'h0001;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m, input logic [VW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_mask = m; ld_data = d;
    tick();
    ld_en = 1'b0; ld_mask = '0;
    for (int l = 0; l < LANES; l++)
      if (m[l]) mrf[l][a] = d[l*DATA_W +: DATA_W];
  endtask

  task automatic issue(input logic [2:0] o, input logic s, input logic w,
                       input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] d,
                       input bit use_req, input logic [VW-1:0] req, output int stalls);
    logic [VW-1:0] y;
    bit got;
    stalls = 0;
    got = 0;
    y = '0;
    op = o; sat_en = s; wb_en = w; rs1 = a1; rs2 = a2; rd = d;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1; else stalls++;
      tick();
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no accept in 100 cycles required accept");
    end else begin
      for (int l = 0; l < LANES; l++) y[l*DATA_W +: DATA_W] = ref_alu(o, s, mrf[l][a1], mrf[l][a2]);
      if (w) for (int l = 0; l < LANES; l++) mrf[l][d] = y[l*DATA_W +: DATA_W];
      exp_q.push_back(use_req ? req : y);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending required 0", exp_q.size());
    end
    tick();
  endtask

  initial begin
    int st, st1, st2, st3;
    bit rand_done;
    logic [VW-1:0] rv;

    rst = 1'b0; in_valid = 1'b0; op = '0; sat_en = 1'b0; wb_en = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; ld_en = 1'b0; ld_addr = '0; ld_mask = '0; ld_data = '0;
    out_ready = 1'b1;
    rand_done = 0;
    for (int l = 0; l < LANES; l++) for (int r = 0; r < NREG; r++) mrf[l][r] = '0;

    // Monitor: pops and compares every result the consumer takes.
    fork
      begin : monitor
        logic [VW-1:0] e;
        forever begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_result: got %h required no result", result);
            end else begin
              e = exp_q.pop_front();
              check("result", result, e);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", VW'(out_valid), '0);
    check("rst_result", result, '0);
    check("rst_in_ready", VW'(in_ready), '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", VW'(in_ready), VW'(1));
    tick();

    // ADD then PASS readback, with latency check
    do_load(5'd1, '1, {LANES{16'h0003}});
    do_load(5'd2, '1, {LANES{16'h0004}});
    issue(ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1, {LANES{16'h0007}}, st);
    @(negedge clk);
    check("lat_cycle1_out_valid", VW'(out_valid), '0);
    tick();
    @(negedge clk);
    check("lat_cycle2_out_valid", VW'(out_valid), VW'(1));
    tick();
    issue(PASS, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1, {LANES{16'h0007}}, st);
    drain();

    // Saturation
    do_load(5'd1, '1, {LANES{16'h7FFF}});
    do_load(5'd2, '1, {LANES{16'h0001}});
    issue(ADD, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1, {LANES{16'h8000}}, st);
    issue(ADD, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1, {LANES{16'h7FFF}}, st);
    do_load(5'd1, '1, {LANES{16'h8000}});
    issue(SUB, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1, {LANES{16'h8000}}, st);
    do_load(5'd1, '1, {LANES{16'h0100}});
    do_load(5'd2, '1, {LANES{16'h0100}});
    issue(MUL, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1, {LANES{16'h7FFF}}, st);
    issue(MUL, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1, {LANES{16'h0000}}, st);
    drain();

    // Hazard interlock
    do_load(5'd1, '1, {LANES{16'h0001}});
    do_load(5'd2, '1, {LANES{16'h0002}});
    issue(ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1, {LANES{16'h0003}}, st);
    issue(ADD, 1'b0, 1'b1, 5'd3, 5'd1, 5'd4, 1, {LANES{16'h0004}}, st);
    check("hazard_stall_cycles", VW'(st), VW'(1));
    issue(PASS, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 1, {LANES{16'h0004}}, st);
    drain();

    // Backpressure: consumer stalls for 5 cycles while 3 instructions are offered
    do_load(5'd1, '1, {LANES{16'h0005}});
    do_load(5'd2, '1, {LANES{16'h0003}});
    tick();
    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        issue(ADD,  1'b0, 1'b1, 5'd1, 5'd2, 5'd10, 0, '0, st1);
        issue(SUB,  1'b0, 1'b1, 5'd1, 5'd2, 5'd11, 0, '0, st2);
        issue(XOR_, 1'b0, 1'b1, 5'd1, 5'd2, 5'd12, 0, '0, st3);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hold_valid_a", VW'(out_valid), VW'(1));
        check("hold_result_a", result, {LANES{16'h0008}});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hold_valid_b", VW'(out_valid), VW'(1));
        check("hold_result_b", result, {LANES{16'h0008}});
      end
    join
    check("bp_third_stalls", VW'(st3), VW'(3));
    drain();
    issue(PASS, 1'b0, 1'b0, 5'd11, 5'd0, 5'd0, 1, {LANES{16'h0002}}, st);
    issue(PASS, 1'b0, 1'b0, 5'd12, 5'd0, 5'd0, 1, {LANES{16'h0006}}, st);
    drain();

    // Load and writeback to r5 on the same edge
    do_load(5'd6, '1, {LANES{16'h1111}});
    issue(PASS, 1'b0, 1'b1, 5'd6, 5'd0, 5'd5, 1, {LANES{16'h1111}}, st);
    do_load(5'd5, 4'b0101, {LANES{16'hAAAA}});
    issue(PASS, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1, {16'h1111, 16'hAAAA, 16'h1111, 16'hAAAA}, st);
    drain();

    // Reset with two instructions in flight
    out_ready = 1'b0;
    issue(ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd20, 0, '0, st);
    issue(ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd21, 0, '0, st);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", VW'(in_ready), '0);
    tick();
    @(negedge clk);
    check("midrst_out_valid", VW'(out_valid), '0);
    check("midrst_result", result, '0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    for (int l = 0; l < LANES; l++) for (int r = 0; r < NREG; r++) mrf[l][r] = '0;
    @(negedge clk);
    check("midrst_release_in_ready", VW'(in_ready), VW'(1));
    tick();
    out_ready = 1'b1;
    issue(PASS, 1'b0, 1'b0, 5'd20, 5'd0, 5'd0, 1, '0, st);
    issue(PASS, 1'b0, 1'b0, 5'd21, 5'd0, 5'd0, 1, '0, st);
    issue(PASS, 1'b0, 1'b0, 5'd1,  5'd0, 5'd0, 1, '0, st);
    drain();

    // Randomised instruction stream with random consumer backpressure
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < LANES; l++) rv[l*DATA_W +: DATA_W] = pick_val();
      do_load(ADDR_W'(r), '1, rv);
    end
    fork
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 300; n++) begin
          issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                0, '0, st);
          if ($urandom_range(0, 4) == 0) tick();
        end
        rand_done = 1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_alu_array.md
Name: simd_alu_array

Overview:
- Parametrised multi-lane successor to the single-lane register-file + ALU processor.
- LANES identical lanes each own a private register file. All lanes execute one shared instruction: rs1, rs2, rd and op are common, data differs per lane.
- The block is a 2-stage pipeline (operand read, then execute/writeback) with valid/ready handshakes on issue and result, a hazard interlock, a binary opcode and optional signed saturation.

Parameters:
LANES, 4, number of parallel lanes
DATA_W, 16, lane data width in bits
ADDR_W, 5, register address width; each lane holds 2**ADDR_W registers

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  instruction present
in_ready  out  1  instruction accepted when in_valid && in_ready
op  in  3  000 ADD, 001 SUB, 010 BITREV, 011 MUL, 100 AND, 101 OR, 110 XOR, 111 PASS (rs1)
sat_en  in  1  signed saturation for ADD/SUB/MUL
wb_en  in  1  write result back to rd
rs1  in  ADDR_W  source 1 address
rs2  in  ADDR_W  source 2 address
rd  in  ADDR_W  destination address
ld_en  in  1  external register load
ld_addr  in  ADDR_W  load address
ld_mask  in  LANES  per-lane load enable
ld_data  in  LANES*DATA_W  load data; lane i is bits [i*DATA_W +: DATA_W]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  LANES*DATA_W  per-lane results, same packing as ld_data

Behaviour:
- Reset (rst=0 at a clk edge):
  - Clears every register in every lane to 0.
  - Clears S1 valid and S2 valid, so out_valid=0. Sets result=0.
  - Forces in_ready=0 while rst=0.
  - Discards in-flight instructions with no writeback. Ignores ld_en.
- Register file reads are combinational. Writes take effect at the clk edge.
- Accept at edge N: rs1/rs2 data for all lanes, plus op, sat_en, wb_en and rd, are registered into S1.
- Edge N+1 (S1 advancing to S2):
  - The ALU result is registered into result and out_valid=1.
  - If wb_en=1, the same result is written to rd in all lanes at this edge.
  - Issue-to-result latency is 2 cycles; throughput is 1 per cycle.
- s2_adv = !out_valid || out_ready. If out_valid=1 and out_ready=0, result and out_valid hold unchanged and S1 holds.
- Hazard: S1 valid && S1 wb_en && (S1 rd == rs1 || S1 rd == rs2). This applies to all ops, including unary ones.
- in_ready = rst && (!S1 valid || (s2_adv && !hazard)).
- A hazard bubble: S1 advances to S2, S1 becomes empty, and the instruction is accepted on the following cycle, reading the written value. There is no forwarding.
- out_valid drops after out_ready is seen if no new S1 entry advances in that cycle.
- Arithmetic is per lane and modulo 2**DATA_W unless saturated:
  - ADD: a+b.
  - SUB: a-b.
  - MUL: low DATA_W bits of the unsigned product.
  - BITREV: bit-reverse of a; b ignored.
  - AND, OR, XOR: bitwise.
  - PASS: a.
- sat_en=1 treats operands as signed two's complement:
  - ADD, SUB and MUL clamp to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - MUL uses the full 2*DATA_W signed product before clamping.
  - Other ops ignore sat_en.
- External load is independent of the handshake: when ld_en=1, ld_data lane i is written to ld_addr for each lane with ld_mask[i]=1.
- Load vs writeback, same edge, same address: the load wins in masked lanes; writeback still lands in unmasked lanes. Different addresses: both writes occur.
- A load does not trigger the hazard interlock. An instruction accepted in the same cycle as a load to its source reads the pre-load value.

Test Plan:
- Reset then ADD: load r1=0x0003 and r2=0x0004 in all lanes. Issue ADD rd=r3, wb_en=1, out_ready=1. Required: out_valid two cycles after accept, every lane 0x0007, then PASS rs1=r3 returns 0x0007.
- Saturation (DATA_W=16): lane0 r1=0x7FFF, r2=0x0001. ADD with sat_en=0 gives 0x8000; sat_en=1 gives 0x7FFF. SUB 0x8000-0x0001 with sat_en=1 gives 0x8000. MUL 0x0100*0x0100 with sat_en=1 gives 0x7FFF; with sat_en=0 gives 0x0000.
- Hazard: back-to-back ADD r3=r1+r2, then ADD r4=r3+r1, with r1=1, r2=2. Required: in_ready=0 for exactly one cycle, r4=4, results in order 3 then 4.
- Backpressure: hold out_ready=0 for 5 cycles with 3 instructions offered. Required: result stable, in_ready=0 once S1 is full, no writeback of held instructions, all 3 results delivered in order after release.
- Per-lane load/writeback conflict: in the same edge, ld_en to r5 with ld_mask=4'b0101 and ld_data lanes=0xAAAA, plus writeback of 0x1111 to r5. Required: lanes 0 and 2 read 0xAAAA, lanes 1 and 3 read 0x1111.
- Mid-operation reset: assert rst=0 with 2 instructions in flight. Required: out_valid=0 and result=0 next cycle, all registers 0, no writeback occurred, in_ready=1 after rst returns to 1.
